brownout_ctrl: RTL and testbench
================================

BROWNOUT_CTRL -- requirements
Module: brownout_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_W, default 8, width of the settle-time counter and cfg_settle.
REQ-002 SHALL have parameter EVT_W, default 8, width of the saturating trip-event counter.
REQ-003 sys_ck  in  1  single clock; all state updates on rising edge.
REQ-004 sys_rst  in  1  reset, synchronous, active-high.
REQ-005 cfg_we  in  1  one-cycle configuration write strobe.
REQ-006 cfg_ena  in  1  requested monitor enable, captured on cfg_we.
REQ-007 cfg_otrip, cfg_vtrip  in  3 each  requested trip codes, captured on cfg_we.
REQ-008 cfg_settle  in  SETTLE_W  settle time in sys_ck cycles, captured on cfg_we.
REQ-009 irq_clr  in  1  one-cycle clear of sticky irq.
REQ-010 brout_in  in  1  brownout flag from analog/oscillator domain, asynchronous.
REQ-011 otrip_fb, vtrip_fb  in  8 each  one-hot decoded trip codes returned from the brownout macro.
REQ-012 otrip, vtrip  out  3 each  registered trip codes driven to the macro.
REQ-013 ena, force_ena_rc_osc, force_dis_rc_osc, force_short_oneshot  out  1 each  registered macro controls.
REQ-014 state  out  2  FSM state (IDLE=0, SETTLE=1, ARMED=2, TRIPPED=3).
REQ-015 brownout  out  1  qualified brownout indication; irq  out  1  sticky interrupt.
REQ-016 evt_cnt  out  EVT_W  trip-event count; cfg_err  out  1  feedback mismatch flag.

Function
REQ-017 brout_in SHALL pass through a 2-flop synchronizer (brout_s); no other logic shall use brout_in directly.
REQ-018 On cfg_we, otrip/vtrip SHALL take cfg_otrip/cfg_vtrip at the next edge, in every state.
REQ-019 IDLE: ena=0, all force_* =0; cfg_we with cfg_ena=1 -> SETTLE, settle counter loaded with cfg_settle.
REQ-020 SETTLE: ena=1, force_ena_rc_osc=1, force_short_oneshot=1; counter decrements each cycle; counter==0 -> ARMED (cfg_settle=0 gives exactly one SETTLE cycle).
REQ-021 ARMED: ena=1, force_*=0; brout_s=1 -> TRIPPED.
REQ-022 TRIPPED: ena=1, brownout=1; brout_s=0 -> ARMED; brownout=0 in all other states.
REQ-023 cfg_we with cfg_ena=0 SHALL force IDLE at next edge from any state; cfg_we with cfg_ena=1 outside IDLE SHALL restart SETTLE with reload.
REQ-024 cfg_we SHALL take priority over all other transitions in the same cycle.
REQ-025 force_dis_rc_osc SHALL be 0 at all times.
REQ-026 Latency: brout_in high before edge N -> brout_s high after N+1 -> state=TRIPPED, brownout=1 after N+2.
REQ-027 Each ARMED->TRIPPED transition SHALL increment evt_cnt, saturating at all-ones (no wrap).
REQ-028 Feedback check: each *_fb SHALL be encoded to 3 bits; cfg_err registered 1 when state!=IDLE and either fb is not exactly one-hot or its encoding differs from the driven code; else 0.
REQ-029 irq SHALL set on ARMED->TRIPPED or cfg_err 0->1 rise; cleared by irq_clr; set wins over simultaneous clear.
REQ-030 Outputs combinationally derived from state SHALL still be glitch-free (registered) toward the macro.

Reset
REQ-031 sys_rst SHALL, at the next edge, force state=IDLE, otrip=vtrip=0, ena=0, all force_*=0, brownout=0, irq=0, evt_cnt=0, cfg_err=0, settle counter=0, synchronizer flops=0.
REQ-032 sys_rst SHALL override cfg_we, irq_clr and any trip in the same cycle, including mid-SETTLE and TRIPPED.

Verification
REQ-033 Reset, cfg_we ena=1 settle=3 otrip=5 vtrip=2 -> SETTLE for 4 cycles with force_ena_rc_osc=1, force_short_oneshot=1, then ARMED; otrip=5, vtrip=2.
REQ-034 ARMED, brout_in pulse 5 cycles -> TRIPPED two edges later, irq=1, evt_cnt=1; return to ARMED two edges after brout_in falls.
REQ-035 evt_cnt preloaded by 255 trips -> 256th trip keeps evt_cnt=255, irq still sets.
REQ-036 ARMED, otrip=5, otrip_fb=8'h40 -> cfg_err=1, irq=1; otrip_fb=8'h21 -> cfg_err stays 1; otrip_fb=8'h20 -> cfg_err=0.
REQ-037 irq_clr in same cycle as new trip -> irq remains 1; TRIPPED plus cfg_we ena=0 -> IDLE, ena=0, brownout=0 next edge.
REQ-038 sys_rst asserted mid-SETTLE with brout_in=1 -> all outputs at REQ-031 values next edge, evt_cnt=0.

Source files
------------

// File: rtl/brownout_ctrl.sv
// Brownout monitor controller: configures the brownout macro, sequences enable/settle/arm,
// qualifies the synchronized brownout flag, counts trip events and cross-checks the macro feedback.
`timescale 1ns/1ps
module brownout_ctrl #(
  parameter int SETTLE_W = 8,
  parameter int EVT_W    = 8
) (
  input  logic                sys_ck,
  input  logic                sys_rst,
  input  logic                cfg_we,
  input  logic                cfg_ena,
  input  logic [2:0]          cfg_otrip,
  input  logic [2:0]          cfg_vtrip,
  input  logic [SETTLE_W-1:0] cfg_settle,
  input  logic                irq_clr,
  input  logic                brout_in,
  input  logic [7:0]          otrip_fb,
  input  logic [7:0]          vtrip_fb,
  output logic [2:0]          otrip,
  output logic [2:0]          vtrip,
  output logic                ena,
  output logic                force_ena_rc_osc,
  output logic                force_dis_rc_osc,
  output logic                force_short_oneshot,
  output logic [1:0]          state,
  output logic                brownout,
  output logic                irq,
  output logic [EVT_W-1:0]    evt_cnt,
  output logic                cfg_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, ARMED = 2'd2, TRIPPED = 2'd3} state_t;

  state_t              cur_state, nxt_state;
  logic                brout_m, brout_s;
  logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
  logic                trip_evt;
  logic                err_nxt;

  assign state = cur_state;

  // Feedback is bad unless it is exactly the one-hot decode of the code we drive.
  function automatic logic fb_bad(input logic [7:0] fb, input logic [2:0] code);
    logic [2:0] enc;
    logic       one_hot;
    enc = 3'd0;
    for (int i = 0; i < 8; i++)
      if (fb[i]) enc = enc | 3'(i);
    one_hot = (fb != 8'd0) && ((fb & (fb - 8'd1)) == 8'd0);
    return !one_hot || (enc != code);
  endfunction

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    nxt_state  = cur_state;
    settle_nxt = settle_cnt;
    trip_evt   = 1'b0;
    if (cfg_we) begin
      if (cfg_ena) begin
        nxt_state  = SETTLE;
        settle_nxt = cfg_settle;
      end else begin
        nxt_state  = IDLE;
      end
    end else begin
      case (cur_state)
        IDLE:    nxt_state = IDLE;
        SETTLE:  if (settle_cnt == '0) nxt_state = ARMED;
                 else settle_nxt = settle_cnt - 1'b1;
        ARMED:   if (brout_s) begin
                   nxt_state = TRIPPED;
                   trip_evt  = 1'b1;
                 end
        TRIPPED: if (!brout_s) nxt_state = ARMED;
        default: nxt_state = IDLE;
      endcase
    end
    err_nxt = (cur_state != IDLE) && (fb_bad(otrip_fb, otrip) || fb_bad(vtrip_fb, vtrip));
  end

  // Macro controls are decoded from the next state and registered, so they are glitch-free.
  always_ff @(posedge sys_ck) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (sys_rst) begin
      brout_m             <= 1'b0;
      brout_s             <= 1'b0;
      cur_state           <= IDLE;
      settle_cnt          <= '0;
      otrip               <= 3'd0;
      vtrip               <= 3'd0;
      ena                 <= 1'b0;
      force_ena_rc_osc    <= 1'b0;
      force_dis_rc_osc    <= 1'b0;
      force_short_oneshot <= 1'b0;
      brownout            <= 1'b0;
      irq                 <= 1'b0;
      evt_cnt             <= '0;
      cfg_err             <= 1'b0;
    end else begin
      brout_m             <= brout_in;
      brout_s             <= brout_m;
      cur_state           <= nxt_state;
      settle_cnt          <= settle_nxt;
      if (cfg_we) begin
        otrip <= cfg_otrip;
        vtrip <= cfg_vtrip;
      end
      ena                 <= (nxt_state != IDLE);
      force_ena_rc_osc    <= (nxt_state == SETTLE);
      force_dis_rc_osc    <= 1'b0;
      force_short_oneshot <= (nxt_state == SETTLE);
      brownout            <= (nxt_state == TRIPPED);
      if (trip_evt && (evt_cnt != '1))
        evt_cnt <= evt_cnt + 1'b1;
      cfg_err             <= err_nxt;
      irq                 <= trip_evt | (err_nxt & ~cfg_err) | (irq & ~irq_clr);
    end
  end

endmodule

// File: tb/tb_brownout_ctrl.sv
// Self-checking bench for brownout_ctrl: directed scenarios followed by randomized traffic,
// every cycle compared against a behavioural model of the controller.
`timescale 1ns/1ps
module tb_brownout_ctrl;

  localparam int SETTLE_W = 8;
  localparam int EVT_W    = 8;
  localparam int EVT_MAX  = (1 << EVT_W) - 1;

  logic                sys_ck = 1'b0;
  logic                sys_rst, cfg_we, cfg_ena, irq_clr, brout_in;
  logic [2:0]          cfg_otrip, cfg_vtrip;
  logic [SETTLE_W-1:0] cfg_settle;
  logic [7:0]          otrip_fb, vtrip_fb;
  logic [2:0]          otrip, vtrip;
  logic                ena, force_ena_rc_osc, force_dis_rc_osc, force_short_oneshot;
  logic [1:0]          state;
  logic                brownout, irq, cfg_err;
  logic [EVT_W-1:0]    evt_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: mode 0 idle, 1 settling, 2 armed, 3 tripped
  int       m_state, m_settle, m_evt;
  bit       m_irq, m_err;
  bit [2:0] m_otrip, m_vtrip;
  bit       h0, h1;

  brownout_ctrl #(.SETTLE_W(SETTLE_W), .EVT_W(EVT_W)) dut (
    .sys_ck(sys_ck), .sys_rst(sys_rst), .cfg_we(cfg_we), .cfg_ena(cfg_ena),
    .cfg_otrip(cfg_otrip), .cfg_vtrip(cfg_vtrip), .cfg_settle(cfg_settle),
    .irq_clr(irq_clr), .brout_in(brout_in), .otrip_fb(otrip_fb), .vtrip_fb(vtrip_fb),
    .otrip(otrip), .vtrip(vtrip), .ena(ena), .force_ena_rc_osc(force_ena_rc_osc),
    .force_dis_rc_osc(force_dis_rc_osc), .force_short_oneshot(force_short_oneshot),
    .state(state), .brownout(brownout), .irq(irq), .evt_cnt(evt_cnt), .cfg_err(cfg_err)
  );

  always #5 sys_ck = ~sys_ck;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic bit fb_bad(input logic [7:0] fb, input bit [2:0] code);
    return fb != (8'd1 << code);
  endfunction

  task automatic model_edge();
    bit trip, err_new, bs;
    if (sys_rst) begin
      m_state = 0; m_settle = 0; m_evt = 0; m_irq = 0; m_err = 0;
      m_otrip = 0; m_vtrip = 0; h0 = 0; h1 = 0;
      return;
    end
    bs      = h1;
    trip    = 0;
    err_new = (m_state != 0) && (fb_bad(otrip_fb, m_otrip) || fb_bad(vtrip_fb, m_vtrip));
    if (cfg_we) begin
      m_state  = cfg_ena ? 1 : 0;
      m_settle = int'(cfg_settle);
      m_otrip  = cfg_otrip;
      m_vtrip  = cfg_vtrip;
    end else if (m_state == 1) begin
      if (m_settle == 0) m_state = 2;
      else m_settle = m_settle - 1;
    end else if (m_state >= 2) begin
      trip    = (m_state == 2) && bs;
      m_state = bs ? 3 : 2;
    end
    if (trip) m_evt = (m_evt < EVT_MAX) ? m_evt + 1 : EVT_MAX;
    m_irq = trip || (err_new && !m_err) || (m_irq && !irq_clr);
    m_err = err_new;
    h1 = h0;
    h0 = brout_in;
  endtask

  // One clock: advance the model with the applied inputs, then compare every output.
  task automatic step();
    model_edge();
    @(posedge sys_ck);
    #1;
    check("state", state, m_state);
    check("ena", ena, m_state != 0);
    check("force_ena_rc_osc", force_ena_rc_osc, m_state == 1);
    check("force_short_oneshot", force_short_oneshot, m_state == 1);
    check("force_dis_rc_osc", force_dis_rc_osc, 0);
    check("brownout", brownout, m_state == 3);
    check("irq", irq, m_irq);
    check("evt_cnt", evt_cnt, m_evt);
    check("cfg_err", cfg_err, m_err);
    check("otrip", otrip, m_otrip);
    check("vtrip", vtrip, m_vtrip);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    sys_rst = 1; cfg_we = 0; cfg_ena = 0; cfg_otrip = 0; cfg_vtrip = 0; cfg_settle = 0;
    irq_clr = 0; brout_in = 0; otrip_fb = 8'h20; vtrip_fb = 8'h04;
    steps(2);
    check("rst_state", state, 0);
    check("rst_evt", evt_cnt, 0);

    // Configure and settle: settle=3 gives four SETTLE cycles
    sys_rst = 0;
    cfg_we = 1; cfg_ena = 1; cfg_settle = 3; cfg_otrip = 5; cfg_vtrip = 2;
    step();
    cfg_we = 0;
    check("settle_c0", state, 1);
    for (int i = 1; i < 4; i++) begin
      step();
      check("settle_cn", state, 1);
      check("settle_frc", force_ena_rc_osc, 1);
    end
    step();
    check("armed", state, 2);
    check("otrip5", otrip, 5);
    check("vtrip2", vtrip, 2);

    // Five-cycle brownout pulse
    brout_in = 1;
    steps(2);
    check("trip_lat1", state, 2);
    step();
    check("trip_lat2", state, 3);
    check("trip_irq", irq, 1);
    check("trip_evt", evt_cnt, 1);
    steps(2);
    brout_in = 0;
    steps(2);
    check("fall_lat1", state, 3);
    step();
    check("fall_lat2", state, 2);
    irq_clr = 1; step(); irq_clr = 0;
    check("irq_clr", irq, 0);

    // Feedback mismatch handling
    otrip_fb = 8'h40; step();
    check("fb_bad", cfg_err, 1);
    check("fb_irq", irq, 1);
    otrip_fb = 8'h21; step();
    check("fb_multi", cfg_err, 1);
    otrip_fb = 8'h20; step();
    check("fb_ok", cfg_err, 0);
    irq_clr = 1; step(); irq_clr = 0;

    // Preload the event counter to saturation
    for (int t = 0; t < EVT_MAX - 1; t++) begin
      brout_in = 1; steps(3);
      brout_in = 0; steps(3);
    end
    check("evt_full", evt_cnt, EVT_MAX);
    irq_clr = 1; step(); irq_clr = 0;
    brout_in = 1; steps(3);
    check("evt_sat", evt_cnt, EVT_MAX);
    check("evt_sat_irq", irq, 1);

    // irq_clr coinciding with a new trip
    brout_in = 0; steps(3);
    irq_clr = 1; brout_in = 1; steps(3);
    check("clr_vs_set", irq, 1);
    irq_clr = 0;
    cfg_we = 1; cfg_ena = 0; step(); cfg_we = 0;
    check("dis_state", state, 0);
    check("dis_ena", ena, 0);
    check("dis_brownout", brownout, 0);

    // Reset mid-SETTLE with brownout asserted
    cfg_we = 1; cfg_ena = 1; cfg_settle = 10; step(); cfg_we = 0;
    brout_in = 1; steps(2);
    sys_rst = 1; step();
    check("rst2_state", state, 0);
    check("rst2_evt", evt_cnt, 0);
    check("rst2_otrip", otrip, 0);
    sys_rst = 0; brout_in = 0;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      sys_rst    = ($urandom_range(0, 199) == 0);
      cfg_we     = ($urandom_range(0, 23) == 0);
      cfg_ena    = ($urandom_range(0, 3) != 0);
      cfg_settle = SETTLE_W'($urandom_range(0, 6));
      cfg_otrip  = 3'($urandom);
      cfg_vtrip  = 3'($urandom);
      irq_clr    = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) brout_in = ~brout_in;
      otrip_fb   = ($urandom_range(0, 11) == 0) ? 8'($urandom) : (8'd1 << m_otrip);
      vtrip_fb   = ($urandom_range(0, 11) == 0) ? 8'($urandom) : (8'd1 << m_vtrip);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
